// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB first, WIDTH+2 cycles per result.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] areg, breg, psum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sum_bit, carry_nxt, last_bit;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign sum_bit   = areg[0] ^ breg[0] ^ carry;
  assign carry_nxt = maj(areg[0], breg[0], carry);
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-serial control: carry and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          carry <= Cin;
          cnt   <= '0;
        end
        SHIFT: begin
          carry <= carry_nxt;
          if (!last_bit) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      areg <= A;
      breg <= B;
    end else if (state == SHIFT) begin
      areg <= areg >> 1;
      breg <= breg >> 1;
      psum <= {sum_bit, psum[WIDTH-1:1]};
    end
  end

  // Result registers load only on DONE entry, so partial sums are never visible
  always_ff @(posedge clk) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (state == SHIFT && last_bit) begin
      S    <= {sum_bit, psum[WIDTH-1:1]};
      Cout <= carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= carry ^ carry_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed + randomized bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, Cin;
  logic [W-1:0] A, B;
  logic         busy, done, Cout;
  logic [W-1:0] S;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_s = '0;
  logic         exp_c = 1'b0;
  logic         exp_v = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_S"}, 32'(S), 32'(exp_s));
    chk({tag, "_Cout"}, 32'(Cout), 32'(exp_c));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_v));
`endif
  endtask

  // Full operation; poke>0 pulses a conflicting start during that busy cycle.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int poke);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    start = 1'b1; A = a; B = b; Cin = ci;
    tick();
    start = 1'b0; A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    for (int i = 1; i <= W; i++) begin
      chk("busy_during_shift", 32'(busy), 32'd1);
      chk("done_during_shift", 32'(done), 32'd0);
      chk_result("hold_during_shift");
      start = (i == poke);
      if (i == poke) begin A = 8'h01; B = 8'h01; end
      tick();
    end
    start = 1'b0;
    exp_s = sum[W-1:0];
    exp_c = sum[W];
    exp_v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk_result("result");
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk_result("hold_after_done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    tick();
    start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk_result("reset");

    op(8'h00, 8'h00, 1'b0, 0);
    op(8'hFF, 8'h01, 1'b0, 0);
    op(8'h7F, 8'h01, 1'b0, 0);
    op(8'hFF, 8'hFF, 1'b1, 0);
    op(8'hA5, 8'h5A, 1'b0, 0);
    op(8'h80, 8'h80, 1'b0, 3);
    op(8'h7F, 8'h01, 1'b0, 0);

    // Reset at busy cycle 4 discards the operation
    start = 1'b1; A = 8'h12; B = 8'h34; Cin = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_s = '0; exp_c = 1'b0; exp_v = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk_result("midrst");
    for (int i = 0; i < W + 3; i++) begin
      chk("midrst_no_done", 32'(done), 32'd0);
      tick();
    end
    op(8'h55, 8'h2B, 1'b1, 0);

    for (int n = 0; n < 8; n++)
      op(W'($urandom), W'($urandom), 1'($urandom), 0);

    // Start held high: one result every W+2 cycles
    start = 1'b1; A = 8'h03; B = 8'h04; Cin = 1'b0;
    tick();
    for (int cyc = 1; cyc <= 4 * (W + 2); cyc++) begin
      int ph;
      ph = cyc % (W + 2);
      chk("stream_done", 32'(done), 32'(ph == W + 1));
      chk("stream_busy", 32'(busy), 32'(ph >= 1 && ph <= W));
      chk("stream_excl", 32'(busy & done), 32'd0);
      if (ph == W + 1) chk("stream_S", 32'(S), 32'h07);
      tick();
    end
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
